// File: rtl/fft_top_div_seq.sv
// fft_top_div_seq: sequential restoring signed divider with saturated quotient and valid/ready handshakes
module fft_top_div_seq #(
    parameter int DIVIDEND_W = 33,
    parameter int DIVISOR_W  = 15,
    parameter int QUOT_W     = 18
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         ce,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DIVIDEND_W-1:0] dividend,
    input  logic signed [DIVISOR_W-1:0]  divisor,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic        [QUOT_W-1:0]     quotient,
    output logic        [DIVISOR_W-1:0]  remainder,
    output logic                         ovf,
    output logic                         dbz
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;
    localparam logic [QUOT_W-1:0]     QMAX    = {1'b0, {(QUOT_W-1){1'b1}}};
    localparam logic [QUOT_W-1:0]     QMIN    = {1'b1, {(QUOT_W-1){1'b0}}};
    localparam logic [DIVIDEND_W-1:0] POS_LIM = DIVIDEND_W'(QMAX);
    localparam logic [DIVIDEND_W-1:0] NEG_LIM = POS_LIM + 1'b1;

    logic [1:0]            state_q, state_d;
    logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
    logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
    logic [DIVISOR_W-1:0]  rem_q, rem_d;
    logic [5:0]            cnt_q, cnt_d;
    logic                  sd_q, sd_d, sq_q, sq_d, zero_q, zero_d;
    logic [QUOT_W-1:0]     quo_q, quo_d;
    logic [DIVISOR_W-1:0]  rmd_q, rmd_d;
    logic                  ovf_q, ovf_d, dbz_q, dbz_d;
    logic [DIVISOR_W:0]    shifted;
    logic                  ge, sat;

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign quotient  = quo_q;
    assign remainder = rmd_q;
    assign ovf       = ovf_q;
    assign dbz       = dbz_q;
    assign shifted   = {rem_q, dvd_q[DIVIDEND_W-1]};
    assign ge        = shifted >= {1'b0, dvs_q};
    assign sat       = zero_q | (sq_q ? dvd_q > NEG_LIM : dvd_q > POS_LIM);

    // Next-state: operand latch, one restoring step per edge (quotient bits shift into the dividend register), then sign/saturate
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        sd_d    = sd_q;
        sq_d    = sq_q;
        zero_d  = zero_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        ovf_d   = ovf_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d = CALC;
                dvd_d   = dividend[DIVIDEND_W-1] ? -dividend : dividend;
                dvs_d   = divisor[DIVISOR_W-1] ? -divisor : divisor;
                sd_d    = dividend[DIVIDEND_W-1];
                sq_d    = dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
                zero_d  = divisor == '0;
                rem_d   = '0;
                cnt_d   = 6'd32;
                ovf_d   = 1'b0;
                dbz_d   = 1'b0;
            end
            CALC: begin
                rem_d   = ge ? DIVISOR_W'(shifted - {1'b0, dvs_q}) : shifted[DIVISOR_W-1:0];
                dvd_d   = {dvd_q[DIVIDEND_W-2:0], ge};
                cnt_d   = cnt_q - 6'd1;
                state_d = cnt_q == 6'd0 ? FIN : CALC;
            end
            FIN: begin
                quo_d   = sat ? (sq_q ? QMIN : QMAX) : (sq_q ? -dvd_q[QUOT_W-1:0] : dvd_q[QUOT_W-1:0]);
                rmd_d   = zero_q ? '0 : (sd_q ? -rem_q : rem_q);
                ovf_d   = sat;
                dbz_d   = zero_q;
                state_d = DONE;
            end
            default: state_d = out_ready ? IDLE : DONE;
        endcase
    end

    // State registers: async clear, update only on clock-enabled edges
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            sd_q    <= 1'b0;
            sq_q    <= 1'b0;
            zero_q  <= 1'b0;
            quo_q   <= '0;
            rmd_q   <= '0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
        end else if (ce) begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            sd_q    <= sd_d;
            sq_q    <= sq_d;
            zero_q  <= zero_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
        end
    end
endmodule
